// File: rtl/stream_xbar_rr_arbiter_if.sv
// Request/grant bundle between the stream_xbar datapath and one per-output-port
// round-robin packet arbiter.
interface stream_xbar_rr_arbiter_if #(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
);
    logic [S_DATA_COUNT-1:0] req_i;
    logic [S_DATA_COUNT-1:0] last_i;
    logic                    ready_i;
    logic [S_DATA_COUNT-1:0] grant_o;
    logic [T_ID_WIDTH-1:0]   grant_id_o;
    logic                    busy_o;

    modport master (
        output req_i, last_i, ready_i,
        input  grant_o, grant_id_o, busy_o
    );

    modport slave (
        input  req_i, last_i, ready_i,
        output grant_o, grant_id_o, busy_o
    );
endinterface

// File: rtl/stream_xbar_rr_arbiter.sv
// Per-output-port packet arbiter: locks the output to one source from its first
// beat until its last beat is accepted, rotating priority between packets.
module stream_xbar_rr_arbiter #(
    parameter  int S_DATA_COUNT = 2,
    localparam int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_xbar_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                  state_q, state_d;
    logic [T_ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [T_ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [S_DATA_COUNT-1:0] grant_q, grant_d;
    logic                    busy_q, busy_d;

    logic                    owner_fire;
    logic                    owner_last;
    logic [T_ID_WIDTH-1:0]   next_ptr;
    logic [S_DATA_COUNT-1:0] handover_cand;
    logic [T_ID_WIDTH-1:0]   idle_winner;
    logic [T_ID_WIDTH-1:0]   handover_winner;

    // Scan start, start+1, ... wrapping at S_DATA_COUNT rather than at a power of 2.
    function automatic logic [T_ID_WIDTH-1:0] rr_pick(
        input logic [S_DATA_COUNT-1:0] cand,
        input logic [T_ID_WIDTH-1:0]   start
    );
        logic [T_ID_WIDTH-1:0] winner;
        logic                  found;
        int                    pos;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            pos = int'(start) + k;
            if (pos >= S_DATA_COUNT) begin
                pos = pos - S_DATA_COUNT;
            end
            if (!found && cand[T_ID_WIDTH'(pos)]) begin
                winner = T_ID_WIDTH'(pos);
                found  = 1'b1;
            end
        end
        return winner;
    endfunction

    function automatic logic [S_DATA_COUNT-1:0] onehot(input logic [T_ID_WIDTH-1:0] idx);
        logic [S_DATA_COUNT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    always_comb begin
        owner_fire      = bus.req_i[grant_id_q] & bus.ready_i;
        owner_last      = bus.last_i[grant_id_q];
        next_ptr        = (int'(grant_id_q) == S_DATA_COUNT - 1) ? '0
                                                                 : grant_id_q + T_ID_WIDTH'(1);
        handover_cand   = bus.req_i & ~onehot(grant_id_q);
        idle_winner     = rr_pick(bus.req_i, ptr_q);
        handover_winner = rr_pick(handover_cand, next_ptr);

        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_d    = grant_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d    = LOCKED;
                    grant_id_d = idle_winner;
                    grant_d    = onehot(idle_winner);
                    busy_d     = 1'b1;
                end
            end
            LOCKED: begin
                // Only the owner's accepted last beat releases the port; everything else holds.
                if (owner_fire && owner_last) begin
                    ptr_d = next_ptr;
                    if (|handover_cand) begin
                        grant_id_d = handover_winner;
                        grant_d    = onehot(handover_winner);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.grant_id_o = grant_id_q;
    assign bus.busy_o     = busy_q;

endmodule
